adc_serial_capture: RTL and testbench
=====================================

Name: adc_serial_capture

Overview:
- Serial ADC capture engine clocked by the 10 MHz divided clock from the frequency-divider stage; that stage feeds this one directly.
- Paces conversions at a fixed sample rate and drives a 3-wire ADC interface (cs_n, sclk, sdata).
- Deserialises each frame MSB-first and presents a parallel sample with a one-cycle valid strobe to the downstream processing logic.

Parameters:
- DATA_W, 12, width of the sample word kept from each frame.
- FRAME_LEN, 16, sclk rising edges per frame; the upper FRAME_LEN-DATA_W bits must be zero.
- PERIOD, 250, clk cycles between conversion starts (10 MHz/250 = 40 kHz). Legal range: PERIOD >= 2*FRAME_LEN+QUIET+2.
- QUIET, 4, clk cycles cs_n is held high after a frame before IDLE.

Ports:
- clk  in  1  10 MHz clock from the divider stage.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  enables periodic conversions.
- sdata  in  1  serial data from the ADC, changes after sclk falling edges.
- cs_n  out  1  ADC chip select, active low.
- sclk  out  1  serial clock, clk/2 during a frame, idles high.
- data_out  out  DATA_W  last captured sample.
- data_valid  out  1  one-cycle pulse when data_out updates.
- fmt_err  out  1  pulses with data_valid when a leading bit of the frame was nonzero.
- busy  out  1  high from cs_n fall until QUIET ends.

Behaviour:
- Reset values (rst=0, asynchronous): cs_n=1, sclk=1, data_out=0, data_valid=0, fmt_err=0, busy=0, state=IDLE, period counter=0, bit counter=0, shift register=0.
- Reset applied mid-frame aborts the frame immediately. No valid pulse is produced for it.
- Period counter:
  - Counts 0..PERIOD-1 and wraps while en=1.
  - Held at 0 while en=0.
  - A start request occurs when en=1 and the count is 0.
  - The first conversion starts on the first edge after en rises.
- FSM states IDLE, CONV, QUIET:
  - IDLE -> CONV on a start request. At that edge (E0): cs_n=0, busy=1, sclk stays 1, bit counter=0.
  - CONV: sclk toggles every clk edge, so it falls at odd edges E1, E3, … and rises at even edges E2, E4, ….
  - CONV sampling: at each rising edge E2k (k=1..FRAME_LEN), sdata is shifted into the LSB of the shift register and the bit counter increments.
  - CONV -> QUIET at edge E(2*FRAME_LEN+1). At that edge: cs_n=1, sclk=1, data_out = new shift[DATA_W-1:0], data_valid=1, fmt_err = OR of the top FRAME_LEN-DATA_W bits.
  - QUIET: data_valid and fmt_err return to 0 after one cycle. Hold for QUIET cycles, then go to IDLE with busy=0.
- Latency: start edge to data_valid = 2*FRAME_LEN+1 clk cycles (33 at defaults).
- en deasserted during CONV or QUIET: the current frame completes normally, including its valid pulse. No further starts occur.
- en reasserted during busy: the period counter restarts from 0. The start is taken only once state is IDLE. A start request arriving while not IDLE is dropped, not queued.
- data_out holds its value between frames. Only valid completions update it.
- sclk and cs_n are registered outputs and must be glitch-free.

Test Plan:
- Reset: rst=0 during a frame -> cs_n=1, sclk=1, busy=0, data_out=0 within the same cycle. No data_valid after release until a new frame completes.
- Single frame: PERIOD=40, en=1, ADC model drives 16'h0ABC -> cs_n low for 33 cycles, 16 sclk rising edges, data_valid one cycle with data_out=12'hABC, fmt_err=0.
- Periodicity: en held high, PERIOD=40 -> cs_n falling edges exactly 40 cycles apart over 5 frames. Each data_valid lands 33 cycles after its cs_n fall.
- Format error: ADC drives 16'h8FFF -> data_out=12'hFFF, fmt_err=1 coincident with data_valid.
- en dropped mid-frame at bit 6 -> frame completes, data_valid fires once, no further cs_n activity while en=0.
- Bit order and edges: alternating pattern 16'h0555 with sdata changed only on sclk falls -> data_out=12'h555. Also check sclk idles high with cs_n=1 between frames.

Source files
------------

// File: rtl/adc_serial_capture.sv
// Serial ADC capture engine: paces conversions at a fixed sample rate, drives
// a 3-wire ADC interface and deserialises each frame MSB-first into a
// parallel sample with a one-cycle valid strobe.
//
// Ports:
//   clk        in   10 MHz clock from the divider stage
//   rst        in   asynchronous active-low reset
//   en         in   enables periodic conversions
//   sdata      in   serial data from the ADC (changes after sclk falls)
//   cs_n       out  ADC chip select, active low
//   sclk       out  serial clock, clk/2 during a frame, idles high
//   data_out   out  last captured sample (DATA_W bits)
//   data_valid out  one-cycle pulse when data_out updates
//   fmt_err    out  pulses with data_valid when a leading frame bit was set
//   busy       out  high from cs_n fall until the quiet time ends
module adc_serial_capture #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned PERIOD    = 250,
  parameter int unsigned QUIET     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sdata,
  output logic              cs_n,
  output logic              sclk,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              fmt_err,
  output logic              busy
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned BIT_W = $clog2(FRAME_LEN + 1);
  localparam int unsigned Q_W   = $clog2(QUIET + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    QUIET_ST = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [Q_W-1:0]         quiet_q, quiet_d;
  logic [FRAME_LEN-1:0]   shift_q, shift_d;
  logic                   cs_n_d, sclk_d, valid_d, err_d, busy_d;
  logic [DATA_W-1:0]      data_d;
  logic                   start_c;

  // Start request: enabled and the sample-rate counter sits at zero.
  assign start_c = en && (period_q == '0);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      period_q   <= '0;
      bit_q      <= '0;
      quiet_q    <= '0;
      shift_q    <= '0;
      cs_n       <= 1'b1;
      sclk       <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      fmt_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      bit_q      <= bit_d;
      quiet_q    <= quiet_d;
      shift_q    <= shift_d;
      cs_n       <= cs_n_d;
      sclk       <= sclk_d;
      data_out   <= data_d;
      data_valid <= valid_d;
      fmt_err    <= err_d;
      busy       <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    quiet_d  = quiet_q;
    shift_d  = shift_q;
    cs_n_d   = cs_n;
    sclk_d   = sclk;
    data_d   = data_out;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    busy_d   = busy;

    // Sample-rate counter free-runs while enabled, parked at zero otherwise.
    if (!en) begin
      period_d = '0;
    end else if (period_q == CNT_W'(PERIOD - 1)) begin
      period_d = '0;
    end else begin
      period_d = period_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = CONV;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          sclk_d  = 1'b1;
          bit_d   = '0;
        end
      end

      CONV: begin
        if (bit_q == BIT_W'(FRAME_LEN)) begin
          // All bits in (sclk is high here): close the frame and publish.
          state_d = QUIET_ST;
          cs_n_d  = 1'b1;
          sclk_d  = 1'b1;
          data_d  = shift_q[DATA_W-1:0];
          valid_d = 1'b1;
          err_d   = ((shift_q >> DATA_W) != '0);
          quiet_d = '0;
        end else begin
          sclk_d = ~sclk;
          // This edge raises sclk: capture the bit the ADC set up on the fall.
          if (!sclk) begin
            shift_d = {shift_q[FRAME_LEN-2:0], sdata};
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end

      QUIET_ST: begin
        if (quiet_q == Q_W'(QUIET - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          quiet_d = quiet_q + Q_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed self-checking bench for adc_serial_capture with a behavioural
// ADC that shifts out a 16-bit word MSB-first, changing sdata on sclk falls.
module tb_adc_serial_capture;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned FLEN   = 16;
  localparam int unsigned PER    = 40;
  localparam int unsigned QT     = 4;

  logic              clk;
  logic              rst;
  logic              en;
  logic              sdata;
  logic              cs_n;
  logic              sclk;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              fmt_err;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [15:0] adc_word;
  int          idx;

  adc_serial_capture #(
    .DATA_W(DATA_W), .FRAME_LEN(FLEN), .PERIOD(PER), .QUIET(QT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sdata(sdata),
    .cs_n(cs_n), .sclk(sclk), .data_out(data_out),
    .data_valid(data_valid), .fmt_err(fmt_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model
  always @(negedge cs_n) idx = 0;
  always @(negedge sclk) begin
    if (!cs_n && idx < 16) begin
      sdata = adc_word[15 - idx];
      idx++;
    end
  end

  task automatic test_reset();
    rst = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got=%b exp=1", sclk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (data_out !== 12'h000) begin errors++; $display("FAIL reset_data got=%h exp=000", data_out); end
    checks++; if ({data_valid, fmt_err} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {data_valid, fmt_err}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Starts one frame with en pulsed (or held for drop_after cycles), watches 100 cycles.
  task automatic test_frame(input logic [15:0] w, input logic [11:0] exp_d,
                            input logic exp_e, input int drop_after, input string name);
    int low, rises, busy_n, nvalid, falls, s, vcyc;
    logic prev_sclk, prev_cs, e;
    logic [11:0] d;
    adc_word = w;
    en = 1'b1;
    @(negedge clk);
    s = cyc; low = 0; rises = 0; busy_n = 0; nvalid = 0; falls = 0; vcyc = -1;
    d = '0; e = 1'b0;
    prev_sclk = sclk; prev_cs = cs_n;
    for (int i = 0; i < 100; i++) begin
      if (i == drop_after) en = 1'b0;
      if (!cs_n) low++;
      if (busy) busy_n++;
      if (!prev_sclk && sclk) rises++;
      if (prev_cs && !cs_n) falls++;
      if (data_valid) begin nvalid++; vcyc = cyc; d = data_out; e = fmt_err; end
      prev_sclk = sclk; prev_cs = cs_n;
      @(negedge clk);
    end
    checks++; if (low !== 33) begin errors++; $display("FAIL %s cs_low_cycles got=%0d exp=33", name, low); end
    checks++; if (rises !== 16) begin errors++; $display("FAIL %s sclk_rises got=%0d exp=16", name, rises); end
    checks++; if (busy_n !== 37) begin errors++; $display("FAIL %s busy_cycles got=%0d exp=37", name, busy_n); end
    checks++; if (nvalid !== 1) begin errors++; $display("FAIL %s valid_count got=%0d exp=1", name, nvalid); end
    checks++; if (falls !== 0) begin errors++; $display("FAIL %s extra_cs_falls got=%0d exp=0", name, falls); end
    checks++; if (vcyc - s !== 33) begin errors++; $display("FAIL %s latency got=%0d exp=33", name, vcyc - s); end
    checks++; if (d !== exp_d) begin errors++; $display("FAIL %s data got=%h exp=%h", name, d, exp_d); end
    checks++; if (e !== exp_e) begin errors++; $display("FAIL %s fmt_err got=%b exp=%b", name, e, exp_e); end
    checks++; if ({cs_n, sclk, busy} !== 3'b110) begin errors++; $display("FAIL %s idle_pins got=%b exp=110", name, {cs_n, sclk, busy}); end
    checks++; if (data_out !== exp_d) begin errors++; $display("FAIL %s data_hold got=%h exp=%h", name, data_out, exp_d); end
  endtask

  task automatic test_periodicity();
    int fc[$];
    int vc[$];
    logic [11:0] vd[$];
    logic prev_cs;
    adc_word = 16'h0123;
    en = 1'b1;
    @(negedge clk);
    prev_cs = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (prev_cs && !cs_n) fc.push_back(cyc);
      if (data_valid) begin vc.push_back(cyc); vd.push_back(data_out); end
      prev_cs = cs_n;
      if (i == 199) en = 1'b0;
      @(negedge clk);
    end
    repeat (60) @(negedge clk);
    checks++; if (fc.size() !== 5) begin errors++; $display("FAIL period_fall_count got=%0d exp=5", fc.size()); end
    checks++; if (vc.size() !== 5) begin errors++; $display("FAIL period_valid_count got=%0d exp=5", vc.size()); end
    for (int k = 1; k < fc.size(); k++) begin
      checks++;
      if (fc[k] - fc[k-1] !== 40) begin errors++; $display("FAIL period_spacing[%0d] got=%0d exp=40", k, fc[k] - fc[k-1]); end
    end
    for (int k = 0; k < fc.size() && k < vc.size(); k++) begin
      checks++;
      if (vc[k] - fc[k] !== 33) begin errors++; $display("FAIL period_latency[%0d] got=%0d exp=33", k, vc[k] - fc[k]); end
      checks++;
      if (vd[k] !== 12'h123) begin errors++; $display("FAIL period_data[%0d] got=%h exp=123", k, vd[k]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int nvalid, lowc;
    adc_word = 16'h0FFF;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL midreset_in_frame cs_n got=%b exp=0", cs_n); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if ({cs_n, sclk, busy} !== 3'b110) begin errors++; $display("FAIL midreset_pins got=%b exp=110", {cs_n, sclk, busy}); end
    checks++; if (data_out !== 12'h000) begin errors++; $display("FAIL midreset_data got=%h exp=000", data_out); end
    @(negedge clk);
    rst = 1'b1;
    nvalid = 0; lowc = 0;
    for (int i = 0; i < 80; i++) begin
      if (data_valid) nvalid++;
      if (!cs_n) lowc++;
      @(negedge clk);
    end
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL midreset_no_valid got=%0d exp=0", nvalid); end
    checks++; if (lowc !== 0) begin errors++; $display("FAIL midreset_cs_quiet got=%0d exp=0", lowc); end
  endtask

  initial begin
    sdata = 1'b0; adc_word = 16'h0000; en = 1'b0; rst = 1'b0; idx = 0;
    test_reset();
    test_frame(16'h0ABC, 12'hABC, 1'b0, 0, "single");
    test_frame(16'h8FFF, 12'hFFF, 1'b1, 0, "fmt_err");
    test_frame(16'h0555, 12'h555, 1'b0, 0, "bit_order");
    test_frame(16'h0F0F, 12'hF0F, 1'b0, 12, "en_drop");
    test_periodicity();
    test_reset_mid_frame();
    test_frame(16'h7321, 12'h321, 1'b1, 0, "recovery");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
